cla_word_sequencer: RTL

- Sits directly upstream and downstream of the 32-bit carry-lookahead adder (thirty_two_bit_cla).
- Takes multi-word operand pairs, least-significant word first, on a valid/ready stream.
- Drives the adder's A/B/Cin and registers its S/Cout, chaining the carry between words so one 32-bit CLA performs N×32-bit additions.
- Emits sum words on a valid/ready output stream with final carry and signed-overflow flags.

---
 rtl/cla_word_sequencer_pkg.sv | 20 ++
 rtl/cla_seq_out_reg.sv | 59 +++++
 rtl/cla_word_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/cla_word_sequencer_pkg.sv
// Shared types and helpers for the multi-word CLA sequencer.
// Build option: CLA_SEQ_SUBTRACT_EN enables per-packet subtraction.
package cla_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  function automatic logic ovf_f(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_seq_out_reg.sv
// One-deep valid/ready result register for the CLA sequencer.
// Holds sum word and packet flags until the consumer takes them.
module cla_seq_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_s,
  input  logic              i_last,
  input  logic              i_cout,
  input  logic              i_ovf,
  input  logic              i_err,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_s,
  output logic              o_last,
  output logic              o_cout,
  output logic              o_ovf,
  output logic              o_err,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_s;
  logic              r_last;
  logic              r_cout;
  logic              r_ovf;
  logic              r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_s     <= '0;
      r_last  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_s     <= i_s;
      r_last  <= i_last;
      r_cout  <= i_cout;
      r_ovf   <= i_ovf;
      r_err   <= i_err;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_s     = r_s;
  assign o_last  = r_last;
  assign o_cout  = r_cout;
  assign o_ovf   = r_ovf;
  assign o_err   = r_err;

endmodule

// File: rtl/cla_word_sequencer.sv
// Chains one 32-bit CLA across multi-word operands, LS word first.
// Build option: CLA_SEQ_SUBTRACT_EN adds in_sub (A - B per packet).
module cla_word_sequencer #(
  parameter int DATA_W    = cla_pkg::DATA_W,
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = $clog2(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CLA_SEQ_SUBTRACT_EN
  input  logic              in_sub,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic [DATA_W-1:0] cla_a,
  output logic [DATA_W-1:0] cla_b,
  output logic              cla_cin,
  input  logic [DATA_W-1:0] cla_s,
  input  logic              cla_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              out_err
);

  import cla_pkg::*;

  state_t           r_state;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sub;
  logic             w_free;
  logic             w_acc;
  logic             w_force;
  logic             w_end;
  logic             w_ovf;

`ifdef CLA_SEQ_SUBTRACT_EN
  logic r_sub;

  // Operation is latched from the first word and held for the packet.
  assign w_sub = (r_state == IDLE) ? in_sub : r_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (w_acc && r_state == IDLE) begin
      r_sub <= in_sub;
    end
  end
`else
  assign w_sub = 1'b0;
`endif

  assign cla_a   = in_a;
  assign cla_b   = w_sub ? ~in_b : in_b;
  assign cla_cin = (r_state == IDLE) ? w_sub : r_carry;

  assign in_ready = w_free;
  assign w_acc    = in_valid && w_free;
  assign w_force  = (r_cnt == CNT_W'(MAX_WORDS - 1));
  assign w_end    = in_last || w_force;
  assign w_ovf    = ovf_f(in_a[DATA_W-1], cla_b[DATA_W-1],
                          cla_s[DATA_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_acc) begin
      if (w_end) begin
        r_state <= IDLE;
        r_carry <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_state <= BUSY;
        r_carry <= cla_cout;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  cla_seq_out_reg #(
    .DATA_W (DATA_W)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_acc),
    .i_s     (cla_s),
    .i_last  (w_end),
    .i_cout  (w_end && cla_cout),
    .i_ovf   (w_end && w_ovf),
    .i_err   (w_force && !in_last),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_s     (out_s),
    .o_last  (out_last),
    .o_cout  (out_cout),
    .o_ovf   (out_ovf),
    .o_err   (out_err),
    .o_free  (w_free)
  );

endmodule
